// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus arbiter and its users.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [31:0] SWITCHES_ADDR = 32'h0000_1000;
  localparam logic [31:0] LEDS_ADDR     = 32'h0000_1004;
  localparam logic [31:0] SEG1_ADDR     = 32'h0000_1008;
  localparam logic [31:0] SEG2_ADDR     = 32'h0000_100C;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Bundle of both master request ports and the shared peripheral port.
interface mmio_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [2:0]        m0_funct3;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [2:0]        m1_funct3;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              io_we;
  logic [ADDR_W-1:0] io_a;
  logic [DATA_W-1:0] io_wd;
  logic [2:0]        io_funct3;
  logic [DATA_W-1:0] io_rd;

  // Arbiter side: consumes master requests and peripheral read data.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_funct3,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_funct3,
    input  io_rd,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output io_we, io_a, io_wd, io_funct3
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_funct3,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_funct3,
    output io_rd,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  io_we, io_a, io_wd, io_funct3
  );
endinterface

// File: rtl/mmio_rr_pick.sv
// Combinational two-way round-robin selector: on a tie the master that
// did not win last time is chosen.
module mmio_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'b0;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_grant_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for the MMIO peripheral port; each access runs as a
// fixed IDLE -> GRANT -> RESP transaction.
module mmio_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  mmio_bus_arbiter_if.slave   bus,
  output logic                busy,
  output logic                owner
);
  import mmio_pkg::*;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              io_we_q, io_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [2:0]        cmd_funct3_q, cmd_funct3_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              pick_valid_s, pick_winner_s;

  mmio_rr_pick u_pick (
    .req_i        ({bus.m1_req, bus.m0_req}),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid_s),
    .winner_o     (pick_winner_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_valid_s ? GRANT : IDLE;
      GRANT:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // io_we is set only on the arbitration edge, so it is high for GRANT alone
  // and the async reset drops it immediately if a store is in flight.
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    io_we_d      = 1'b0;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_funct3_d = cmd_funct3_q;
    rdata_d      = rdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          owner_d      = pick_winner_s;
          last_grant_d = pick_winner_s;
          io_we_d      = pick_winner_s ? bus.m1_we     : bus.m0_we;
          cmd_addr_d   = pick_winner_s ? bus.m1_addr   : bus.m0_addr;
          cmd_wdata_d  = pick_winner_s ? bus.m1_wdata  : bus.m0_wdata;
          cmd_funct3_d = pick_winner_s ? bus.m1_funct3 : bus.m0_funct3;
        end else begin
          io_we_d = 1'b0;
        end
      end
      GRANT: begin
        rdata_d = bus.io_rd;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
      end
      RESP:    ack0_d = 1'b0;
      default: ack0_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      io_we_q      <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_funct3_q <= 3'b000;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      io_we_q      <= io_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_funct3_q <= cmd_funct3_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.io_we     = io_we_q;
  assign bus.io_a      = cmd_addr_q;
  assign bus.io_wd     = cmd_wdata_q;
  assign bus.io_funct3 = cmd_funct3_q;
  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.m0_rdata  = rdata_q;
  assign bus.m1_rdata  = rdata_q;
  assign busy          = busy_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: vector table, hand-written contention/reset
// sequences and a randomized run against a transaction-level model.
module tb_mmio_bus_arbiter;
  import mmio_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy, owner;
  int   checks = 0;
  int   errors = 0;

  mmio_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mmio_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  // Peripheral: switches (read-only), 4-bit LEDs, two 8-bit 7-seg registers.
  logic [3:0] sw_r   = 4'h0;
  logic [3:0] leds_r = 4'h0;
  logic [7:0] seg1_r = 8'h00;
  logic [7:0] seg2_r = 8'h00;

  always_comb begin
    case (bus.io_a)
      SWITCHES_ADDR: bus.io_rd = {28'h0, sw_r};
      LEDS_ADDR:     bus.io_rd = {28'h0, leds_r};
      SEG1_ADDR:     bus.io_rd = {24'h0, seg1_r};
      SEG2_ADDR:     bus.io_rd = {24'h0, seg2_r};
      default:       bus.io_rd = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.io_we) begin
      case (bus.io_a)
        LEDS_ADDR: leds_r <= bus.io_wd[3:0];
        SEG1_ADDR: seg1_r <= bus.io_wd[7:0];
        SEG2_ADDR: seg2_r <= bus.io_wd[7:0];
        default:   ;
      endcase
    end
  end

  // Reference model state: what the peripheral should hold, and who won last.
  logic [3:0] m_leds;
  logic [7:0] m_seg1, m_seg2;
  bit         lg_m;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (a == SWITCHES_ADDR) return {28'h0, sw_r};
    if (a == LEDS_ADDR)     return {28'h0, m_leds};
    if (a == SEG1_ADDR)     return {24'h0, m_seg1};
    if (a == SEG2_ADDR)     return {24'h0, m_seg2};
    return 32'h0;
  endfunction

  function automatic void mwr(input logic [31:0] a, input logic [31:0] d);
    if (a == LEDS_ADDR) m_leds = d[3:0];
    if (a == SEG1_ADDR) m_seg1 = d[7:0];
    if (a == SEG2_ADDR) m_seg2 = d[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'h0; bus.m0_wdata = 32'h0; bus.m0_funct3 = 3'b000;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'h0; bus.m1_wdata = 32'h0; bus.m1_funct3 = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst io_we",  {31'h0, bus.io_we}, 32'h0);
    chk("rst io_a",   bus.io_a, 32'h0);
    chk("rst io_wd",  bus.io_wd, 32'h0);
    chk("rst io_f3",  {29'h0, bus.io_funct3}, 32'h0);
    chk("rst acks",   {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
    chk("rst rdata",  bus.m0_rdata, 32'h0);
    chk("rst busy",   {31'h0, busy}, 32'h0);
    chk("rst owner",  {31'h0, owner}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Start requests on the enabled masters in an IDLE cycle; each master drops
  // req at the edge that ends its ack cycle. Times are cycles from start.
  task automatic run_pair(input bit en0, input bit en1, input bit we0, input bit we1,
                          input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1,
                          input logic [2:0] f3,
                          output int t0, output int t1,
                          output logic [31:0] r0, output logic [31:0] r1,
                          output int wecnt, output int spur,
                          output logic [31:0] a_g, output logic [2:0] f_g);
    bit done0, done1;
    t0 = -1; t1 = -1; r0 = 32'h0; r1 = 32'h0; wecnt = 0; spur = 0; a_g = 32'h0; f_g = 3'b000;
    bus.m0_we = we0; bus.m0_addr = a0; bus.m0_wdata = d0; bus.m0_funct3 = f3; bus.m0_req = en0;
    bus.m1_we = we1; bus.m1_addr = a1; bus.m1_wdata = d1; bus.m1_funct3 = f3; bus.m1_req = en1;
    done0 = !en0;
    done1 = !en1;
    for (int i = 0; i < 20 && !(done0 && done1); i++) begin
      @(negedge clk);
      if (bus.io_we) wecnt++;
      if (i == 1) begin a_g = bus.io_a; f_g = bus.io_funct3; end
      if (bus.m0_ack && done0) spur++;
      if (bus.m1_ack && done1) spur++;
      if (bus.m0_ack && !done0) begin t0 = i; r0 = bus.m0_rdata; done0 = 1'b1; end
      if (bus.m1_ack && !done1) begin t1 = i; r1 = bus.m1_rdata; done1 = 1'b1; end
      @(posedge clk); #1;
      if (done0) bus.m0_req = 1'b0;
      if (done1) bus.m1_req = 1'b0;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
  endtask

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0, t1, wecnt, spur, n;
    logic [31:0] r0, r1, a_g;
    logic [2:0]  f_g;
    int who[4], when[4];
    logic [31:0] addrs[5];

    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, wecnt, spur, n, acks;
    logic [31:0] r0, r1, a_g;
    logic [2:0]  f_g;
    int who[4], when[4];
    logic [31:0] addrs[5];
    bit en[2], we[2], first;
    logic [31:0] a[2], d[2], exp_r[2];

    vecs[0] = '{1'b0, 1'b1, LEDS_ADDR,     32'h0000_0005, F3_WORD, 32'h0};
    vecs[1] = '{1'b1, 1'b0, SWITCHES_ADDR, 32'h0,         F3_WORD, 32'h0000_000A};
    vecs[2] = '{1'b0, 1'b0, LEDS_ADDR,     32'h0,         F3_BYTE, 32'h0000_0005};
    vecs[3] = '{1'b1, 1'b1, SEG1_ADDR,     32'h0000_0077, F3_BYTE, 32'h0};
    vecs[4] = '{1'b0, 1'b0, SEG1_ADDR,     32'h0,         F3_HALF, 32'h0000_0077};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_2000, 32'h0,         F3_WORD, 32'h0};
    vecs[6] = '{1'b1, 1'b0, SEG2_ADDR,     32'h0,         F3_WORD, 32'h0};

    sw_r = 4'hA;
    apply_reset();

    for (int k = 0; k < 7; k++) begin
      run_pair(!vecs[k].m, vecs[k].m, vecs[k].we, vecs[k].we, vecs[k].addr, vecs[k].wdata,
               vecs[k].addr, vecs[k].wdata, vecs[k].f3, t0, t1, r0, r1, wecnt, spur, a_g, f_g);
      chk($sformatf("vec%0d latency", k), 32'(vecs[k].m ? t1 : t0), 32'd2);
      chk($sformatf("vec%0d other ack", k), 32'(spur + (vecs[k].m ? (t0 >= 0) : (t1 >= 0))), 32'd0);
      chk($sformatf("vec%0d io_we cycles", k), 32'(wecnt), {31'h0, vecs[k].we});
      chk($sformatf("vec%0d io_a", k), a_g, vecs[k].addr);
      chk($sformatf("vec%0d io_funct3", k), {29'h0, f_g}, {29'h0, vecs[k].f3});
      if (!vecs[k].we)
        chk($sformatf("vec%0d rdata", k), vecs[k].m ? r1 : r0, vecs[k].exp_rd);
      if (k == 0) chk("leds after store", {28'h0, leds_r}, 32'h5);
      chk($sformatf("vec%0d owner", k), {31'h0, owner}, {31'h0, vecs[k].m});
    end

    // First tie after reset: master 0 wins, master 1 follows three cycles later.
    apply_reset();
    run_pair(1'b1, 1'b1, 1'b1, 1'b1, SEG1_ADDR, 32'h3F, SEG2_ADDR, 32'h06, F3_BYTE,
             t0, t1, r0, r1, wecnt, spur, a_g, f_g);
    chk("tie1 m0 ack", 32'(t0), 32'd2);
    chk("tie1 m1 ack", 32'(t1), 32'd5);
    chk("tie1 spurious", 32'(spur), 32'd0);
    chk("tie1 seg1", {24'h0, seg1_r}, 32'h3F);
    chk("tie1 seg2", {24'h0, seg2_r}, 32'h06);

    run_pair(1'b1, 1'b1, 1'b0, 1'b0, SEG1_ADDR, 32'h0, SEG2_ADDR, 32'h0, F3_WORD,
             t0, t1, r0, r1, wecnt, spur, a_g, f_g);
    chk("tie2 m0 ack", 32'(t0), 32'd2);
    chk("tie2 m1 ack", 32'(t1), 32'd5);
    chk("tie2 m0 rdata", r0, 32'h3F);
    chk("tie2 m1 rdata", r1, 32'h06);
    chk("tie2 io_we", 32'(wecnt), 32'd0);
    chk("tie2 owner", {31'h0, owner}, 32'h1);

    // Both masters hold req continuously: grants must alternate every 3 cycles.
    bus.m0_we = 1'b0; bus.m0_addr = SEG1_ADDR; bus.m0_req = 1'b1;
    bus.m1_we = 1'b0; bus.m1_addr = SEG2_ADDR; bus.m1_req = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin who[k] = -1; when[k] = -1; end
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      if (bus.m0_ack && bus.m1_ack) chk("alt double ack", 32'h1, 32'h0);
      if (bus.m0_ack) begin who[n] = 0; when[n] = i; chk("alt m0 rdata", bus.m0_rdata, 32'h3F); n++; end
      else if (bus.m1_ack) begin who[n] = 1; when[n] = i; chk("alt m1 rdata", bus.m1_rdata, 32'h06); n++; end
      @(posedge clk); #1;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    chk("alt ack count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("alt%0d winner", k), 32'(who[k]), 32'(k % 2));
      chk($sformatf("alt%0d cycle", k), 32'(when[k]), 32'(2 + 3 * k));
    end

    // Reset while an m0 store to the LEDs sits in GRANT.
    bus.m0_we = 1'b1; bus.m0_addr = LEDS_ADDR; bus.m0_wdata = 32'hC; bus.m0_funct3 = F3_WORD;
    bus.m0_req = 1'b1;
    @(posedge clk); #1;
    chk("abort io_we in grant", {31'h0, bus.io_we}, 32'h1);
    #2 reset = 1'b1;
    #1 chk("abort io_we async", {31'h0, bus.io_we}, 32'h0);
    bus.m0_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort owner", {31'h0, owner}, 32'h0);
        chk("abort io_a", bus.io_a, 32'h0);
      end
      if (bus.m0_ack || bus.m1_ack || bus.io_we) acks++;
    end
    chk("abort no ack", 32'(acks), 32'd0);
    chk("abort leds", {28'h0, leds_r}, 32'h5);
    @(posedge clk); #1;

    // Randomized traffic against the transaction-level model.
    m_leds = 4'h5; m_seg1 = 8'h3F; m_seg2 = 8'h06; lg_m = 1'b1;
    addrs[0] = SWITCHES_ADDR; addrs[1] = LEDS_ADDR; addrs[2] = SEG1_ADDR;
    addrs[3] = SEG2_ADDR;     addrs[4] = 32'h0000_2000;
    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      en[0] = (mode != 1);
      en[1] = (mode != 0);
      sw_r  = 4'($urandom);
      for (int k = 0; k < 2; k++) begin
        we[k] = 1'($urandom);
        a[k]  = addrs[$urandom_range(0, 4)];
        d[k]  = $urandom;
        exp_r[k] = 32'h0;
      end
      first = (en[0] && en[1]) ? !lg_m : !en[0];
      if (!we[first]) exp_r[first] = mrd(a[first]); else mwr(a[first], d[first]);
      lg_m = first;
      if (en[0] && en[1]) begin
        if (!we[!first]) exp_r[!first] = mrd(a[!first]); else mwr(a[!first], d[!first]);
        lg_m = !first;
      end
      run_pair(en[0], en[1], we[0], we[1], a[0], d[0], a[1], d[1], F3_WORD,
               t0, t1, r0, r1, wecnt, spur, a_g, f_g);
      if (en[0]) chk($sformatf("rnd%0d m0 ack", it), 32'(t0), (first == 1'b0) ? 32'd2 : 32'd5);
      if (en[1]) chk($sformatf("rnd%0d m1 ack", it), 32'(t1), (first == 1'b1) ? 32'd2 : 32'd5);
      if (en[0] && !we[0]) chk($sformatf("rnd%0d m0 rdata", it), r0, exp_r[0]);
      if (en[1] && !we[1]) chk($sformatf("rnd%0d m1 rdata", it), r1, exp_r[1]);
      chk($sformatf("rnd%0d spurious", it), 32'(spur), 32'd0);
      chk($sformatf("rnd%0d io_we cycles", it), 32'(wecnt), 32'((en[0] && we[0]) + (en[1] && we[1])));
      chk($sformatf("rnd%0d owner", it), {31'h0, owner}, {31'h0, lg_m});
    end
    chk("rnd final leds", {28'h0, leds_r}, {28'h0, m_leds});
    chk("rnd final seg1", {24'h0, seg1_r}, {24'h0, m_seg1});
    chk("rnd final seg2", {24'h0, seg2_r}, {24'h0, m_seg2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
